// File: rtl/rgbw_pwm_decoder.sv
// rgbw_pwm_decoder
// Four-channel PWM capture. Each channel measures the rise-to-rise period and the
// high time of its input in clk cycles. It reports each result with a one-cycle
// valid strobe. It also flags inputs that stay at a constant level (0 % / 100 % duty).
module rgbw_pwm_decoder #(
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [3:0]           pwm_i,
  output logic [4*CNT_W-1:0]   high_o,
  output logic [4*CNT_W-1:0]   period_o,
  output logic [3:0]           valid_o,
  output logic [3:0]           stuck_o,
  output logic [3:0]           level_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic             s1_reg, s2_reg, s3_reg;
      logic             rise;
      state_t           state_reg;
      logic [CNT_W-1:0] per_cnt_reg, hi_cnt_reg;
      logic [CNT_W-1:0] high_reg, period_reg;
      logic             valid_reg, stuck_reg, level_reg;

      // Every edge passes through the same two flops, so the latency is the same for
      // every edge and the measured widths are exact.
      assign rise = s2_reg & ~s3_reg;

      // Two-flop synchroniser followed by a delay flop for edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
          s3_reg <= 1'b0;
        end else begin
          s1_reg <= pwm_i[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end

      // Channel measurement FSM with registered result, strobe and stuck flags.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg   <= IDLE;
          per_cnt_reg <= '0;
          hi_cnt_reg  <= '0;
          high_reg    <= '0;
          period_reg  <= '0;
          valid_reg   <= 1'b0;
          stuck_reg   <= 1'b0;
          level_reg   <= 1'b0;
        end else begin
          valid_reg <= 1'b0;
          if (!ena) begin
            // Discard any measurement in progress. Published results and flags are held.
            state_reg   <= IDLE;
            per_cnt_reg <= '0;
            hi_cnt_reg  <= '0;
          end else begin
            case (state_reg)
              IDLE: begin
                per_cnt_reg <= '0;
                hi_cnt_reg  <= '0;
                if (rise) begin
                  // The first edge only opens a measurement window.
                  state_reg   <= MEAS;
                  per_cnt_reg <= CNT_ONE;
                  hi_cnt_reg  <= CNT_ONE;
                  stuck_reg   <= 1'b0;
                end
              end
              MEAS: begin
                if (rise) begin
                  // A rise wins over a timeout in the same cycle.
                  high_reg    <= hi_cnt_reg;
                  period_reg  <= per_cnt_reg;
                  valid_reg   <= 1'b1;
                  per_cnt_reg <= CNT_ONE;
                  hi_cnt_reg  <= CNT_ONE;
                  stuck_reg   <= 1'b0;
                end else if (per_cnt_reg == TIMEOUT_C) begin
                  stuck_reg   <= 1'b1;
                  level_reg   <= s2_reg;
                  high_reg    <= s2_reg ? CNT_MAX : '0;
                  period_reg  <= '0;
                  valid_reg   <= 1'b1;
                  state_reg   <= IDLE;
                  per_cnt_reg <= '0;
                  hi_cnt_reg  <= '0;
                end else begin
                  if (per_cnt_reg != CNT_MAX) per_cnt_reg <= per_cnt_reg + CNT_ONE;
                  if (s2_reg && (hi_cnt_reg != CNT_MAX)) hi_cnt_reg <= hi_cnt_reg + CNT_ONE;
                end
              end
              default: begin
                state_reg   <= IDLE;
                per_cnt_reg <= '0;
                hi_cnt_reg  <= '0;
              end
            endcase
          end
        end
      end

      assign high_o[gi*CNT_W +: CNT_W]   = high_reg;
      assign period_o[gi*CNT_W +: CNT_W] = period_reg;
      assign valid_o[gi]                 = valid_reg;
      assign stuck_o[gi]                 = stuck_reg;
      assign level_o[gi]                 = level_reg;
    end
  endgenerate

endmodule

// File: doc/rgbw_pwm_decoder.md
Name: rgbw_pwm_decoder

Overview:
- Four-channel PWM capture block: the reader for the RGBW lamp's PWM outputs.
- Per channel, measures rise-to-rise period and high time in clk cycles and reports them with a one-cycle valid strobe.
- Flags channels stuck at a constant level (0 % or 100 % duty).
- Used as a loopback checker and readback path beside the lamp controller in the tt08 design.

Parameters:
- CNT_W, 16, width of each period/high-time counter and result field.
- TIMEOUT, 16'hFFFF, cycles without a rising edge before a channel is declared stuck; legal range 4 to 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; when 0, all channel FSMs are held in IDLE and counters are cleared; outputs hold their last values.
- pwm_i  in  4  PWM inputs; bit0=R, bit1=G, bit2=B, bit3=W; asynchronous to clk.
- high_o  out  4*CNT_W  latched high time per channel; channel n occupies bits [n*CNT_W +: CNT_W].
- period_o  out  4*CNT_W  latched period per channel, same packing as high_o.
- valid_o  out  4  one-cycle pulse per channel when that channel's high_o/period_o are updated.
- stuck_o  out  4  per-channel flag: no rising edge seen for TIMEOUT cycles.
- level_o  out  4  per-channel synchronised input level, captured when stuck_o is set.

Behaviour:
- Reset: all outputs 0, all synchronisers 0, all FSMs in IDLE. Reset acts immediately and asynchronously, including mid-measurement; no partial result is ever emitted.
- Synchronisation, per channel:
  - two flops s1→s2, plus a delay flop s3;
  - rise = s2 & ~s3;
  - a pin rising edge is seen by the FSM 2-3 clk later; the latency is identical for every edge, so measured widths are exact for inputs that are stable ≥2 cycles.
- Channel FSM, IDLE state:
  - per_cnt and hi_cnt are held at 0.
  - On rise: go to MEAS, set per_cnt=1 and hi_cnt=1.
- Channel FSM, MEAS state, each cycle without rise:
  - per_cnt += 1;
  - hi_cnt += 1 if s2=1;
  - both counters saturate at all-ones.
- MEAS, cycle with rise:
  - high_o[n] ← hi_cnt and period_o[n] ← per_cnt (the pre-update values);
  - valid_o[n]=1 for exactly this cycle;
  - per_cnt←1, hi_cnt←1, stay in MEAS;
  - stuck_o[n]←0.
- MEAS, per_cnt reaches TIMEOUT (checked before increment, no rise this cycle):
  - stuck_o[n]←1, level_o[n]←s2;
  - high_o[n] ← s2 ? all-ones : 0;
  - period_o[n]←0;
  - valid_o[n]=1 for one cycle;
  - go to IDLE.
- IDLE, first rise after a stuck episode: clears stuck_o[n] immediately; the next valid result comes one full period later.
- Simultaneous rise and timeout in the same cycle: rise wins; a normal measurement is latched.
- The first rise after reset or after stuck only starts a measurement; no valid pulse is emitted for it.
- Channels are fully independent; any combination of valid_o bits may pulse in the same cycle.
- ena falling mid-measurement: the current measurement is discarded, the FSM goes to IDLE, and stuck_o/level_o are unchanged.
- Result invariant: hi_cnt ≤ per_cnt ≤ TIMEOUT for every valid measurement.

Test Plan:
- Single-channel basic measurement (TIMEOUT=1000): drive pwm_i[0] with period 100, 25 cycles high.
  - Required: no valid on the first rise.
  - Then valid_o[0] every 100 cycles with high_o[0]=25, period_o[0]=100.
  - Other channels: valid_o=0, outputs 0.
- Channel independence: drive R/G/B/W simultaneously with period 256 and high 0x40/0x80/0xC0/0xFF.
  - Required: each channel reports its own high value with period 256.
  - Valid pulses coincide when the input edges are aligned.
- Stuck low (TIMEOUT=1000): one valid period, then hold pwm_i[1]=0.
  - Required: exactly 1000 cycles after the last rise was detected, a single valid_o[1] with high_o[1]=0, period_o[1]=0, stuck_o[1]=1, level_o[1]=0.
  - No further pulses while the input stays low.
- Stuck high (TIMEOUT=1000): hold pwm_i[2]=1 after a rise.
  - Required: stuck_o[2]=1, level_o[2]=1, high_o[2]=16'hFFFF.
  - Resuming a 50/100 PWM clears stuck_o[2] on the first rise and reports 50/100 one period later.
- Reset mid-operation: assert rst_n=0 for 3 cycles, 60 cycles into a period.
  - Required: all outputs 0 asynchronously.
  - After release, the first valid appears only after two rising edges.
- Enable gating: drop ena mid-period, then raise it again.
  - Required: no valid while ena=0.
  - Previous high_o/period_o are held.
  - Measurement restarts cleanly after ena=1.
